// File: rtl/hleaf_router.sv
// Leaf router of the hierarchical NoC tree: NumLeaf leaf ports plus one centre uplink,
// with one FIFO per input, one round-robin arbiter per output and registered outputs.
module hleaf_router #(
  parameter int DataWidth = 32,
  parameter int NumLeaf   = 4,
  parameter int AddrWidth = 4,
  parameter int BaseAddr  = 0,
  parameter int FifoDepth = 4
) (
  input  logic                         i_mclk,
  input  logic                         i_reset,
  input  logic [NumLeaf*DataWidth-1:0] i_leaf_data,
  input  logic [NumLeaf-1:0]           i_leaf_data_valid,
  output logic [NumLeaf-1:0]           o_leaf_data_ready,
  output logic [NumLeaf*DataWidth-1:0] o_leaf_data,
  output logic [NumLeaf-1:0]           o_leaf_data_valid,
  input  logic [NumLeaf-1:0]           i_leaf_data_ready,
  input  logic [DataWidth-1:0]         i_centre_data,
  input  logic                         i_centre_data_valid,
  output logic                         o_centre_data_ready,
  output logic [DataWidth-1:0]         o_centre_data,
  output logic                         o_centre_data_valid,
  input  logic                         i_centre_data_ready,
  output logic [15:0]                  o_drop_count
);

  localparam int NumPort      = NumLeaf + 1;
  localparam int PortW        = $clog2(NumPort);
  localparam int IdxW         = $clog2(FifoDepth);
  localparam int CntW         = IdxW + 1;
  localparam int LastLeafAddr = BaseAddr + NumLeaf - 1;

  logic [DataWidth-1:0] inData    [NumPort];
  logic [NumPort-1:0]   inValid;
  logic [NumPort-1:0]   downReady;

  logic [DataWidth-1:0] fifoMem   [NumPort][FifoDepth];
  logic [IdxW-1:0]      rdPtr     [NumPort];
  logic [IdxW-1:0]      wrPtr     [NumPort];
  logic [CntW-1:0]      fifoCount [NumPort];
  logic [CntW-1:0]      nextCount [NumPort];
  logic [NumPort-1:0]   inReady;
  logic [NumPort-1:0]   push;
  logic [NumPort-1:0]   pop;

  logic [DataWidth-1:0] headData  [NumPort];
  logic [PortW-1:0]     target    [NumPort];
  logic [NumPort-1:0]   headValid;
  logic [NumPort-1:0]   headLocal;
  logic [NumPort-1:0]   routable;
  logic                 dropHead;

  logic [NumPort-1:0]   outLoad;
  logic [NumPort-1:0]   anyGrant;
  logic [PortW-1:0]     winner    [NumPort];
  logic [PortW-1:0]     rrPtr     [NumPort];
  logic [DataWidth-1:0] outData   [NumPort];
  logic [NumPort-1:0]   outValid;
  logic [15:0]          dropCount;

  assign inValid         = {i_centre_data_valid, i_leaf_data_valid};
  assign downReady       = {i_centre_data_ready, i_leaf_data_ready};
  assign inData[NumLeaf] = i_centre_data;

  for (genvar k = 0; k < NumLeaf; k++) begin : gLeafPack
    assign inData[k]                             = i_leaf_data[k*DataWidth +: DataWidth];
    assign o_leaf_data[k*DataWidth +: DataWidth] = outData[k];
  end

  // Decode each FIFO head; a centre head with no local destination is simply discarded.
  always_comb begin
    int destAddr;
    destAddr = 0;
    for (int i = 0; i < NumPort; i++) begin
      headData[i]  = fifoMem[i][rdPtr[i]];
      headValid[i] = fifoCount[i] != '0;
      destAddr     = int'(headData[i][DataWidth-1 -: AddrWidth]);
      headLocal[i] = (destAddr >= BaseAddr) && (destAddr <= LastLeafAddr);
      target[i]    = headLocal[i] ? PortW'(destAddr - BaseAddr) : PortW'(NumLeaf);
      routable[i]  = headValid[i] && (headLocal[i] || (i != NumLeaf));
    end
    dropHead = headValid[NumLeaf] && !headLocal[NumLeaf];
  end

  always_comb begin
    int idx;
    idx = 0;
    pop = '0;
    pop[NumLeaf] = dropHead;
    for (int o = 0; o < NumPort; o++) begin
      outLoad[o]  = !outValid[o] || downReady[o];
      anyGrant[o] = 1'b0;
      winner[o]   = '0;
      for (int off = 0; off < NumPort; off++) begin
        idx = int'(rrPtr[o]) + off;
        if (idx >= NumPort) idx = idx - NumPort;
        if (outLoad[o] && !anyGrant[o] && routable[idx] && (target[idx] == PortW'(o))) begin
          anyGrant[o] = 1'b1;
          winner[o]   = PortW'(idx);
        end
      end
      if (anyGrant[o]) pop[winner[o]] = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NumPort; i++) begin
      push[i]      = inValid[i] && inReady[i];
      nextCount[i] = fifoCount[i] + CntW'(push[i]) - CntW'(pop[i]);
    end
  end

  always_ff @(posedge i_mclk) begin
    for (int i = 0; i < NumPort; i++) begin
      if (push[i]) fifoMem[i][wrPtr[i]] <= inData[i];
    end
  end

  // Ready is registered from the next occupancy so it stays low for the cycle after reset.
  always_ff @(posedge i_mclk) begin
    if (i_reset) begin
      inReady <= '0;
      for (int i = 0; i < NumPort; i++) begin
        rdPtr[i]     <= '0;
        wrPtr[i]     <= '0;
        fifoCount[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumPort; i++) begin
        if (push[i]) wrPtr[i] <= wrPtr[i] + IdxW'(1);
        if (pop[i])  rdPtr[i] <= rdPtr[i] + IdxW'(1);
        fifoCount[i] <= nextCount[i];
        inReady[i]   <= nextCount[i] < CntW'(FifoDepth);
      end
    end
  end

  always_ff @(posedge i_mclk) begin
    if (i_reset) begin
      outValid  <= '0;
      dropCount <= '0;
      for (int o = 0; o < NumPort; o++) begin
        outData[o] <= '0;
        rrPtr[o]   <= '0;
      end
    end else begin
      for (int o = 0; o < NumPort; o++) begin
        if (outLoad[o]) begin
          outValid[o] <= anyGrant[o];
          if (anyGrant[o]) begin
            outData[o] <= headData[winner[o]];
            rrPtr[o]   <= (winner[o] == PortW'(NumLeaf)) ? '0 : winner[o] + PortW'(1);
          end
        end
      end
      if (dropHead && (dropCount != 16'hFFFF)) dropCount <= dropCount + 16'd1;
    end
  end

  assign o_leaf_data_ready   = inReady[NumLeaf-1:0];
  assign o_centre_data_ready = inReady[NumLeaf];
  assign o_leaf_data_valid   = outValid[NumLeaf-1:0];
  assign o_centre_data_valid = outValid[NumLeaf];
  assign o_centre_data       = outData[NumLeaf];
  assign o_drop_count        = dropCount;

endmodule

// File: tb/tb_hleaf_router.sv
// Bench for hleaf_router: directed vector table, hand-written corner sequences and random
// traffic scored against a queue of expected (destination, word) pairs.
`timescale 1ns/1ps
module tb_hleaf_router;

  localparam int DataWidth = 32;
  localparam int NumLeaf   = 4;
  localparam int AddrWidth = 4;
  localparam int BaseAddr  = 0;
  localparam int FifoDepth = 4;
  localparam int NumPort   = NumLeaf + 1;
  localparam int Centre    = NumLeaf;

  logic                         mclk = 1'b0;
  logic                         reset;
  logic [NumLeaf*DataWidth-1:0] leafIn;
  logic [NumLeaf-1:0]           leafInValid;
  logic [NumLeaf-1:0]           leafInReady;
  logic [NumLeaf*DataWidth-1:0] leafOut;
  logic [NumLeaf-1:0]           leafOutValid;
  logic [NumLeaf-1:0]           leafOutReady;
  logic [DataWidth-1:0]         centreIn;
  logic                         centreInValid;
  logic                         centreInReady;
  logic [DataWidth-1:0]         centreOut;
  logic                         centreOutValid;
  logic                         centreOutReady;
  logic [15:0]                  dropCount;

  hleaf_router #(
    .DataWidth(DataWidth), .NumLeaf(NumLeaf), .AddrWidth(AddrWidth),
    .BaseAddr(BaseAddr), .FifoDepth(FifoDepth)
  ) dut (
    .i_mclk(mclk), .i_reset(reset),
    .i_leaf_data(leafIn), .i_leaf_data_valid(leafInValid), .o_leaf_data_ready(leafInReady),
    .o_leaf_data(leafOut), .o_leaf_data_valid(leafOutValid), .i_leaf_data_ready(leafOutReady),
    .i_centre_data(centreIn), .i_centre_data_valid(centreInValid), .o_centre_data_ready(centreInReady),
    .o_centre_data(centreOut), .o_centre_data_valid(centreOutValid), .i_centre_data_ready(centreOutReady),
    .o_drop_count(dropCount)
  );

  always #5 mclk = ~mclk;

  int checks = 0;
  int errors = 0;

  typedef struct { int dst; logic [31:0] word; } expT;
  typedef struct { int src; logic [31:0] word; int dst; } vecT;

  expT              expQ[$];
  int               modelDrops = 0;
  logic [NumPort-1:0] stalled = '0;
  logic [31:0]      stallWord [NumPort];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] makeWord(input int dest, input int src, input int seq);
    return {4'(dest), 4'(src), 8'h00, 16'(seq)};
  endfunction

  function automatic logic [31:0] inWord(input int p);
    return (p == Centre) ? centreIn : leafIn[p*DataWidth +: DataWidth];
  endfunction

  function automatic logic [31:0] outWord(input int p);
    return (p == Centre) ? centreOut : leafOut[p*DataWidth +: DataWidth];
  endfunction

  function automatic logic [NumPort-1:0] allOutValid();
    return {centreOutValid, leafOutValid};
  endfunction

  // Destination port of a word, or -1 when the router must discard it.
  function automatic int routeOf(input int src, input logic [31:0] w);
    int dest;
    dest = int'(w[31:28]);
    if (dest >= BaseAddr && dest < BaseAddr + NumLeaf) return dest - BaseAddr;
    if (src == Centre) return -1;
    return Centre;
  endfunction

  task automatic applyStimulus(input int port, input logic [31:0] word, input logic valid);
    if (port == Centre) begin
      centreIn      = word;
      centreInValid = valid;
    end else begin
      leafIn[port*DataWidth +: DataWidth] = word;
      leafInValid[port]                   = valid;
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  // Mid-cycle scoreboard: handshakes seen here are the ones taken at the next rising edge.
  always @(negedge mclk) begin
    logic [NumPort-1:0] iv, ir, ov, orr;
    logic [31:0] w;
    int r, found;
    expT e;
    iv  = {centreInValid, leafInValid};
    ir  = {centreInReady, leafInReady};
    ov  = allOutValid();
    orr = {centreOutReady, leafOutReady};
    if (reset) begin
      expQ.delete();
      stalled = '0;
    end else begin
      for (int p = 0; p < NumPort; p++) begin
        w = outWord(p);
        if (stalled[p]) begin
          checkOutput($sformatf("holdValid%0d", p), ov[p], 1'b1);
          checkOutput($sformatf("holdData%0d", p), w, stallWord[p]);
        end
        if (iv[p] && ir[p]) begin
          r = routeOf(p, inWord(p));
          if (r < 0) modelDrops++;
          else begin
            e.dst  = r;
            e.word = inWord(p);
            expQ.push_back(e);
          end
        end
        if (ov[p] && orr[p]) begin
          found = -1;
          for (int k = 0; k < expQ.size(); k++)
            if (found < 0 && expQ[k].dst == p && expQ[k].word[27:24] == w[27:24]) found = k;
          checkOutput($sformatf("wordKnown%0d", p), found >= 0, 1'b1);
          if (found >= 0) begin
            checkOutput($sformatf("wordOrder%0d", p), w, expQ[found].word);
            expQ.delete(found);
          end
        end
        stalled[p]   = ov[p] && !orr[p];
        stallWord[p] = w;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecT vecs[10];
    logic [NumPort-1:0] expValid;
    logic [NumPort-1:0] acc;
    int expDrop, lastSrc, src, accepted, sawValid;
    int seq[NumPort];

    vecs[0] = '{0,      32'h2000_00AB, 2};
    vecs[1] = '{1,      32'h9100_0001, Centre};
    vecs[2] = '{Centre, 32'h9400_0002, -1};
    vecs[3] = '{Centre, 32'h3400_0003, 3};
    vecs[4] = '{2,      32'h2200_0004, 2};
    vecs[5] = '{3,      32'h0300_0005, 0};
    vecs[6] = '{0,      32'hF000_0006, Centre};
    vecs[7] = '{Centre, 32'h4400_0007, -1};
    vecs[8] = '{Centre, 32'h0400_0008, 0};
    vecs[9] = '{1,      32'h4100_0009, Centre};

    reset          = 1'b1;
    leafIn         = {4{32'h2000_0001}};
    centreIn       = 32'h1400_0001;
    leafInValid    = '1;
    centreInValid  = 1'b1;
    leafOutReady   = '1;
    centreOutReady = 1'b1;
    repeat (3) tick();
    checkOutput("rstLeafValid", leafOutValid, '0);
    checkOutput("rstCentreValid", centreOutValid, 1'b0);
    checkOutput("rstLeafData", |leafOut, 1'b0);
    checkOutput("rstCentreData", centreOut, '0);
    checkOutput("rstLeafReady", leafInReady, '0);
    checkOutput("rstCentreReady", centreInReady, 1'b0);
    checkOutput("rstDrop", dropCount, '0);
    reset         = 1'b0;
    leafInValid   = '0;
    centreInValid = 1'b0;
    tick();
    checkOutput("relLeafReady", leafInReady, 4'hF);
    checkOutput("relCentreReady", centreInReady, 1'b1);

    // Single words: idle after acceptance edge, visible one edge later.
    expDrop = 0;
    for (int v = 0; v < 10; v++) begin
      applyStimulus(vecs[v].src, vecs[v].word, 1'b1);
      tick();
      applyStimulus(vecs[v].src, vecs[v].word, 1'b0);
      checkOutput($sformatf("vec%0dEarlyIdle", v), allOutValid(), '0);
      tick();
      expValid = '0;
      if (vecs[v].dst >= 0) expValid[vecs[v].dst] = 1'b1;
      else expDrop++;
      checkOutput($sformatf("vec%0dValid", v), allOutValid(), expValid);
      if (vecs[v].dst >= 0) checkOutput($sformatf("vec%0dWord", v), outWord(vecs[v].dst), vecs[v].word);
      checkOutput($sformatf("vec%0dDrop", v), dropCount, expDrop);
      tick();
    end

    for (int p = 0; p < NumPort; p++) seq[p] = 0;
    lastSrc = -1;
    for (int c = 0; c < 60; c++) begin
      applyStimulus(0, makeWord(2, 0, seq[0]), 1'b1);
      applyStimulus(1, makeWord(2, 1, seq[1]), 1'b1);
      applyStimulus(3, makeWord(2, 3, seq[3]), 1'b1);
      acc = {centreInValid, leafInValid} & {centreInReady, leafInReady};
      tick();
      for (int p = 0; p < NumPort; p++) if (acc[p]) seq[p]++;
      if (leafOutValid[2]) begin
        src = int'(leafOut[2*DataWidth+24 +: 4]);
        if (lastSrc >= 0) checkOutput("rrOrder", src, (lastSrc == 0) ? 1 : (lastSrc == 1) ? 3 : 0);
        lastSrc = src;
      end
    end
    leafInValid = '0;
    repeat (20) tick();
    checkOutput("t4Drained", expQ.size(), 0);

    leafOutReady[1] = 1'b0;
    accepted = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(0, makeWord(1, 0, 500 + accepted), 1'b1);
      acc[0] = leafInReady[0];
      tick();
      if (acc[0]) accepted++;
    end
    checkOutput("t5Accepted", accepted, FifoDepth + 1);
    checkOutput("t5ReadyLow", leafInReady[0], 1'b0);
    applyStimulus(0, '0, 1'b0);
    leafOutReady[1] = 1'b1;
    repeat (12) tick();
    checkOutput("t5Drained", expQ.size(), 0);

    leafOutReady[2] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(0, makeWord(2, 0, 100 + c), 1'b1);
      tick();
    end
    applyStimulus(0, '0, 1'b0);
    reset = 1'b1;
    tick();
    checkOutput("t6ValidAfterReset", allOutValid(), '0);
    reset        = 1'b0;
    leafOutReady = '1;
    sawValid     = 0;
    repeat (6) begin
      tick();
      if (|allOutValid()) sawValid = 1;
    end
    checkOutput("t6NoStale", sawValid, 0);
    applyStimulus(3, makeWord(1, 3, 7), 1'b1);
    tick();
    applyStimulus(3, '0, 1'b0);
    tick();
    checkOutput("t6NewValid", allOutValid(), 5'b00010);
    checkOutput("t6NewWord", outWord(1), makeWord(1, 3, 7));
    tick();

    // Random traffic with random downstream backpressure.
    modelDrops = int'(dropCount);
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < NumPort; p++) begin
        applyStimulus(p, makeWord($urandom_range(0, 15), p, seq[p]), $urandom_range(0, 99) < 60);
        seq[p]++;
      end
      leafOutReady   = 4'($urandom);
      centreOutReady = 1'($urandom);
      tick();
    end
    leafInValid    = '0;
    centreInValid  = 1'b0;
    leafOutReady   = '1;
    centreOutReady = 1'b1;
    repeat (30) tick();
    checkOutput("randDrained", expQ.size(), 0);
    checkOutput("randDropCount", dropCount, modelDrops);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
